sum_display: RTL and testbench

SUM_DISPLAY -- requirements
Module: sum_display

---
 rtl/sum_display_pkg.sv | 27 ++
 rtl/sum_display_seg7_decode.sv | 14 +
 rtl/sum_display.sv | 103 ++++++++++
 tb/tb_sum_display.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/sum_display_pkg.sv
// Shared types and constants for the sum display: FSM states and active-low 7-segment patterns.
package sum_display_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        LOAD = 2'd2
    } state_t;

    // Active-low {g,f,e,d,c,b,a}; entry i is digit i.
    localparam logic [9:0][6:0] SEG_TABLE = {
        7'b0010000,  // 9
        7'b0000000,  // 8
        7'b1111000,  // 7
        7'b0000010,  // 6
        7'b0010010,  // 5
        7'b0011001,  // 4
        7'b0110000,  // 3
        7'b0100100,  // 2
        7'b1111001,  // 1
        7'b1000000   // 0
    };

    localparam logic [6:0] SEG_BLANK  = 7'b1111111;
    localparam int         CONV_STEPS = 5;

endpackage

// File: rtl/sum_display_seg7_decode.sv
// BCD digit to active-low 7-segment pattern; purely combinational, codes above 9 blank the digit.
module seg7_decode
    import sum_display_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        if (bcd < 4'd10) seg = SEG_TABLE[bcd];
    end

endmodule

// File: rtl/sum_display.sv
// Converts a 5-bit sum to two BCD digits (double dabble) and multiplexes them onto a 2-digit display.
// Display registers update 7 edges after a new SUM is sampled; SUM changes during a conversion are ignored.
module sum_display
    import sum_display_pkg::*;
#(
    parameter int REFRESH_DIV = 100000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [4:0] SUM,
    output logic [6:0] SEG,
    output logic [1:0] AN,
    output logic       DP,
    output logic       BUSY
);

    localparam int             CW      = $clog2(REFRESH_DIV);
    localparam logic [CW-1:0]  CNT_MAX = CW'(REFRESH_DIV - 1);

    state_t        state;
    logic [4:0]    last_val;
    logic [4:0]    cap;
    logic [4:0]    shift;
    logic [7:0]    bcd;
    logic [7:0]    bcd_adj;
    logic [2:0]    step;
    logic [3:0]    tens;
    logic [3:0]    ones;
    logic [CW-1:0] rcnt;
    logic          dsel;
    logic [3:0]    digit;
    logic [6:0]    dec_seg;

    always_comb begin
        bcd_adj = bcd;
        if (bcd[3:0] >= 4'd5) bcd_adj[3:0] = bcd[3:0] + 4'd3;
        if (bcd[7:4] >= 4'd5) bcd_adj[7:4] = bcd[7:4] + 4'd3;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            last_val <= '0;
            cap      <= '0;
            shift    <= '0;
            bcd      <= '0;
            step     <= '0;
            tens     <= '0;
            ones     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (SUM != last_val) begin
                        cap   <= SUM;
                        shift <= SUM;
                        bcd   <= '0;
                        step  <= '0;
                        state <= CONV;
                    end
                end
                CONV: begin
                    bcd   <= (bcd_adj << 1) | {7'd0, shift[4]};
                    shift <= {shift[3:0], 1'b0};
                    step  <= step + 3'd1;
                    if (step == 3'(CONV_STEPS - 1)) state <= LOAD;
                end
                LOAD: begin
                    tens     <= bcd[7:4];
                    ones     <= bcd[3:0];
                    last_val <= cap;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Free-running digit refresh, deliberately decoupled from the converter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rcnt <= '0;
            dsel <= 1'b0;
        end else if (rcnt == CNT_MAX) begin
            rcnt <= '0;
            dsel <= ~dsel;
        end else begin
            rcnt <= rcnt + 1'b1;
        end
    end

    assign digit = dsel ? tens : ones;

    seg7_decode u_seg7_decode (
        .bcd (digit),
        .seg (dec_seg)
    );

    assign SEG  = (dsel && tens == 4'd0) ? SEG_BLANK : dec_seg;
    assign AN   = dsel ? 2'b01 : 2'b10;
    assign DP   = 1'b1;
    assign BUSY = (state != IDLE);

endmodule

// File: tb/tb_sum_display.sv
// Random and directed stimulus for sum_display, checked every cycle against a behavioural display model.
module tb_sum_display;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b1;
    logic [4:0] SUM   = 5'd0;
    logic [6:0] SEG;
    logic [1:0] AN;
    logic       DP;
    logic       BUSY;

    int n_chk  = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    logic [6:0] tbl [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                             7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

    always #5 clk = ~clk;

    sum_display #(.REFRESH_DIV(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .SUM   (SUM),
        .SEG   (SEG),
        .AN    (AN),
        .DP    (DP),
        .BUSY  (BUSY)
    );

    // Model: a new value shown 7 edges after it is sampled, busy for the 6 cycles in between.
    int m_last  = 0;
    int m_disp  = 0;
    int m_pend  = 0;
    int m_busy  = 0;
    int m_ticks = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_last  <= 0;
            m_disp  <= 0;
            m_pend  <= 0;
            m_busy  <= 0;
            m_ticks <= 0;
        end else begin
            m_ticks <= m_ticks + 1;
            if (m_busy == 0) begin
                if (int'(SUM) != m_last) begin
                    m_pend <= int'(SUM);
                    m_busy <= 6;
                end
            end else begin
                m_busy <= m_busy - 1;
                if (m_busy == 1) begin
                    m_last <= m_pend;
                    m_disp <= m_pend;
                end
            end
        end
    end

    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int exp_seg();
        int sel;
        int tens;
        int ones;
        sel  = (m_ticks / 4) % 2;
        tens = m_disp / 10;
        ones = m_disp % 10;
        if (sel == 0) return int'(tbl[ones]);
        if (tens == 0) return 32'h7f;
        return int'(tbl[tens]);
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            check("seg", int'(SEG), exp_seg());
            check("an", int'(AN), (((m_ticks / 4) % 2) == 1) ? 1 : 2);
            check("dp", int'(DP), 1);
            check("busy", int'(BUSY), (m_busy > 0) ? 1 : 0);
        end
    end

    task automatic show(input string tag, input logic [6:0] et, input logic [6:0] eo);
        logic [6:0] t = 7'h00;
        logic [6:0] o = 7'h00;
        repeat (8) begin
            @(negedge clk);
            if (AN == 2'b01) t = SEG;
            else if (AN == 2'b10) o = SEG;
        end
        check({tag, "_tens"}, int'(t), int'(et));
        check({tag, "_ones"}, int'(o), int'(eo));
    endtask

    task automatic busy_count(input int cycles, inout int cnt);
        repeat (cycles) begin
            @(negedge clk);
            if (BUSY) cnt++;
        end
    endtask

    initial begin
        int         nb;
        int         run;
        bit         seen;
        logic [1:0] prev;

        #1 rst_n = 1'b0;
        #20 chk_en = 1'b1;
        @(negedge clk);
        check("rst_seg", int'(SEG), 32'h40);
        check("rst_an", int'(AN), 2);
        @(negedge clk);
        #2 rst_n = 1'b1;

        // Idle with SUM=0: zero on ones, blank on tens.
        nb = 0;
        busy_count(12, nb);
        check("idle_busy", nb, 0);
        show("zero", 7'b1111111, 7'b1000000);

        SUM = 5'd23;
        nb  = 0;
        busy_count(10, nb);
        check("busy23", nb, 6);
        show("v23", 7'b0100100, 7'b0110000);

        SUM = 5'd31;
        repeat (10) @(negedge clk);
        show("v31", 7'b0110000, 7'b1111001);

        SUM = 5'd9;
        repeat (10) @(negedge clk);
        show("v9", 7'b1111111, 7'b0010000);

        // Change during CONV is deferred to a second conversion.
        SUM = 5'd5;
        repeat (10) @(negedge clk);
        SUM = 5'd12;
        nb  = 0;
        busy_count(3, nb);
        SUM = 5'd7;
        busy_count(20, nb);
        check("busy_12_7", nb, 12);
        show("v7", 7'b1111111, 7'b1111000);

        // Reset mid-conversion.
        SUM = 5'd18;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("abort_seg", int'(SEG), 32'h40);
        check("abort_an", int'(AN), 2);
        check("abort_busy", int'(BUSY), 0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (7) @(negedge clk);
        show("v18", 7'b1111001, 7'b0000000);

        // AN period across a conversion.
        SUM  = 5'd30;
        prev = AN;
        run  = 0;
        seen = 1'b0;
        repeat (24) begin
            @(negedge clk);
            run++;
            if (AN != prev) begin
                if (seen) check("an_period", run, 4);
                seen = 1'b1;
                run  = 0;
                prev = AN;
            end
        end

        for (int i = 0; i < 40; i++) begin
            SUM = 5'($urandom_range(0, 31));
            repeat ($urandom_range(1, 10)) @(negedge clk);
        end
        repeat (12) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
